// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction store.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int DEFAULT_DEPTH  = 32;
  localparam int DEFAULT_CNT_W  = 8;

  function automatic logic [31:0] word_byte_addr(input logic [31:0] idx);
    return {idx[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-store write port of the loader.
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  // master: the loader itself; slave: the host link plus the store
  modport master (
    input  rx_data, rx_valid,
    output rx_ready, wr_en, wr_addr, wr_data
  );
  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_word_assembler.sv
// Packs accepted bytes MSB-first into a 32-bit word and pulses word_ready_o
// in the cycle after the last byte of each word.
module imem_word_assembler
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        last_byte_o,
  output logic        word_ready_o
);

  logic [1:0]  cnt_q;
  logic [31:0] word_q;
  logic        word_ready_q;

  assign last_byte_o = shift_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      word_q       <= '0;
      word_ready_q <= 1'b0;
    end else begin
      word_ready_q <= last_byte_o;
      if (clear_i) begin
        cnt_q <= '0;
      end else if (shift_i) begin
        cnt_q  <= cnt_q + 2'd1;
        word_q <= {word_q[23:0], byte_i};
      end
    end
  end

  assign word_o       = word_q;
  assign word_ready_o = word_ready_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: length byte, N big-endian words, XOR checksum byte.
//   state | meaning
//   IDLE  | waiting for start, stream not accepted
//   LEN   | expecting word-count byte
//   DATA  | receiving instruction bytes, writing each completed word
//   CSUM  | expecting checksum byte
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          cpu_hold,
  output logic          done,
  output logic          error,
  imem_loader_if.master bus
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] n_q, idx_q;
  logic [7:0]       csum_q;
  logic [31:0]      wr_addr_q;
  logic             rx_ready_q, rx_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic             xfer, start_acc, shift_en, last_byte, len_bad, last_word;
  logic [CNT_W-1:0] len_val;

  assign xfer      = bus.rx_valid && rx_ready_q;
  assign start_acc = start && (state_q == IDLE);
  assign shift_en  = xfer && (state_q == DATA);
  assign len_val   = CNT_W'(bus.rx_data);
  assign len_bad   = (len_val == '0) || (len_val > DEPTH_C);
  assign last_word = last_byte && (idx_q == n_q - CNT_W'(1));

  imem_word_assembler u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (start_acc),
    .shift_i      (shift_en),
    .byte_i       (bus.rx_data),
    .word_o       (bus.wr_data),
    .last_byte_o  (last_byte),
    .word_ready_o (bus.wr_en)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start)        state_d = LEN;
      LEN:  if (xfer)         state_d = len_bad ? IDLE : DATA;
      DATA: if (last_word)    state_d = CSUM;
      CSUM: if (xfer)         state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Status flags are computed from the upcoming state so they land with it.
  always_comb begin
    busy_d     = (state_d != IDLE);
    rx_ready_d = (state_d != IDLE);
    done_d     = done_q;
    error_d    = error_q;
    if (start_acc) begin
      done_d  = 1'b0;
      error_d = 1'b0;
    end else if (xfer && (state_q == LEN) && len_bad) begin
      error_d = 1'b1;
    end else if (xfer && (state_q == CSUM)) begin
      done_d  = (bus.rx_data == csum_q);
      error_d = (bus.rx_data != csum_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      rx_ready_q <= rx_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q       <= '0;
      idx_q     <= '0;
      csum_q    <= '0;
      wr_addr_q <= '0;
    end else if (start_acc) begin
      idx_q  <= '0;
      csum_q <= '0;
    end else begin
      if (xfer && (state_q == LEN) && !len_bad) n_q <= len_val;
      if (shift_en) csum_q <= csum_q ^ bus.rx_data;
      if (last_byte) begin
        wr_addr_q <= word_byte_addr(32'(idx_q));
        idx_q     <= idx_q + CNT_W'(1);
      end
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.wr_addr  = wr_addr_q;
  assign busy         = busy_q;
  assign cpu_hold     = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard fed from the stimulus.
module tb_imem_loader;
  import imem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, cpu_hold, done, error;

  imem_loader_if bus ();

  imem_loader #(.DEPTH(32), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [63:0] sb[$];

  always @(negedge clk) begin
    if (rst_n && bus.wr_en) begin
      logic [63:0] exp;
      wr_cnt++;
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL wr_unexpected addr=%h data=%h expected no write", bus.wr_addr, bus.wr_data);
      end
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        checks++;
        assert ({bus.wr_addr, bus.wr_data} === exp) else begin
          errors++;
          $error("FAIL wr_word got %h/%h expected %h/%h", bus.wr_addr, bus.wr_data, exp[63:32], exp[31:0]);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int t = 0;
    int g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (g) @(negedge clk);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
  endtask

  // Full load: length, data (scoreboarded), checksum (optionally corrupted).
  task automatic run_load(input int n, input logic [7:0] data[$], input logic [7:0] csum_flip,
                          input int max_gap);
    logic [7:0]  cs = 8'h00;
    logic [31:0] w  = 32'h0;
    int          wr0;
    do_start();
    chk("busy_rise", 32'(busy), 32'd1);
    chk("hold_rise", 32'(cpu_hold), 32'd1);
    chk("done_clr", 32'(done), 32'd0);
    chk("err_clr", 32'(error), 32'd0);
    wr0 = wr_cnt;
    send_byte(8'(n), max_gap);
    if (n == 0 || n > 32) begin
      chk("badlen_busy", 32'(busy), 32'd0);
      chk("badlen_err", 32'(error), 32'd1);
      chk("badlen_done", 32'(done), 32'd0);
      repeat (3) @(negedge clk);
      chk("badlen_nowrite", 32'(wr_cnt - wr0), 32'd0);
      return;
    end
    for (int i = 0; i < 4 * n; i++) begin
      w  = {w[23:0], data[i]};
      cs = cs ^ data[i];
      if (i % 4 == 3) sb.push_back({32'(i / 4) << 2, w});
      send_byte(data[i], max_gap);
      chk("busy_mid", 32'(busy), 32'd1);
    end
    send_byte(cs ^ csum_flip, max_gap);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_hold", 32'(cpu_hold), 32'd0);
    chk("end_done", 32'(done), (csum_flip == 0) ? 32'd1 : 32'd0);
    chk("end_err", 32'(error), (csum_flip == 0) ? 32'd0 : 32'd1);
    chk("end_writes", 32'(wr_cnt - wr0), 32'(n));
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] d[$];
    logic [7:0] cs;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.rx_ready), 32'd0);
    chk("rst_wren", 32'(bus.wr_en), 32'd0);
    chk("rst_addr", bus.wr_addr, 32'd0);
    chk("rst_data", bus.wr_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", {30'd0, done, error}, 32'd0);
    rst_n = 1'b1;

    // Bytes offered in IDLE must not be taken.
    @(negedge clk) begin bus.rx_data = 8'h55; bus.rx_valid = 1'b1; end
    repeat (2) @(negedge clk);
    chk("idle_ready", 32'(bus.rx_ready), 32'd0);
    bus.rx_valid = 1'b0;

    d = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    run_load(2, d, 8'h00, 0);

    d = {};
    run_load(0, d, 8'h00, 0);
    run_load(33, d, 8'h00, 0);

    d = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_load(1, d, 8'h01, 0);

    d = {};
    for (int i = 0; i < 128; i++) d.push_back(8'($urandom));
    run_load(32, d, 8'h00, 3);

    // Reset in the middle of a load, after the sixth data byte.
    do_start();
    send_byte(8'd2, 0);
    d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    sb.push_back({32'h0, 32'h11223344});
    for (int i = 0; i < 6; i++) send_byte(d[i], 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(bus.rx_ready), 32'd0);
    chk("midrst_data", bus.wr_data, 32'd0);
    chk("midrst_addr", bus.wr_addr, 32'd0);
    chk("midrst_flags", {29'd0, bus.wr_en, done, error}, 32'd0);
    chk("midrst_sb", 32'(sb.size()), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Full load after reset with a stray start pulse between data bytes.
    do_start();
    send_byte(8'd2, 0);
    d  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA5, 8'h5A, 8'hC3, 8'h3C};
    cs = 8'h00;
    sb.push_back({32'h0, 32'h01020304});
    sb.push_back({32'h4, 32'hA55AC33C});
    for (int i = 0; i < 8; i++) begin
      cs = cs ^ d[i];
      send_byte(d[i], 0);
      if (i == 2) begin
        do_start();
        chk("stray_start_busy", 32'(busy), 32'd1);
        chk("stray_start_ready", 32'(bus.rx_ready), 32'd1);
      end
    end
    send_byte(cs, 0);
    chk("rec_busy", 32'(busy), 32'd0);
    chk("rec_done", 32'(done), 32'd1);
    chk("rec_err", 32'(error), 32'd0);
    chk("rec_sb", 32'(sb.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
